arty_btn_debounce: RTL and testbench
====================================

Name: arty_btn_debounce

Overview:
- Push-button conditioning stage between the board BTN pins and the SOC PIO push-button input and IRQ line.
- Synchronises the raw buttons to cpu_clk and debounces each one against a shared millisecond-class tick.
- Emits clean levels, one-cycle press/release strobes, sticky press events and a registered interrupt.

Parameters:
- N_BTN, 4, number of buttons.
- TICK_DIV, 25000, cpu_clk cycles per debounce sample tick (1 ms at 25 MHz); legal range >= 1.
- DB_TICKS, 10, consecutive mismatching ticks required to accept a new level; legal range >= 1.
- CNT_W, $clog2(DB_TICKS+1), derived, not overridable.

Ports:
- cpu_clk  in  1  core clock.
- pwrup_rst_n  in  1  asynchronous active-low reset.
- btn_raw_i  in  N_BTN  raw buttons, active-high, asynchronous to cpu_clk.
- btn_o  out  N_BTN  debounced level.
- btn_press_o  out  N_BTN  one-cycle strobe on a debounced 0->1 transition.
- btn_release_o  out  N_BTN  one-cycle strobe on a debounced 1->0 transition.
- evt_clr_i  in  N_BTN  per-bit clear of sticky events, level-sampled.
- evt_o  out  N_BTN  sticky press events.
- irq_o  out  1  registered OR of evt_o.

Behaviour:
- Reset, clock and sync: reset is pwrup_rst_n, asynchronous, active-low. Clock is cpu_clk.
- All flops reset to 0. btn_o, btn_press_o, btn_release_o, evt_o and irq_o are all 0 in reset.
- Synchroniser: 2-flop synchroniser per bit with reset value 0; sync[i] is btn_raw_i[i] delayed 2 cycles.
- Tick generator:
  - Down-counter, reset value TICK_DIV-1.
  - tick=1 for exactly one cycle when the counter is 0, and the counter reloads TICK_DIV-1 in that cycle. Otherwise it decrements.
  - TICK_DIV=1 gives tick=1 every cycle.
- Per-button cell, one state flop stable[i] plus counter cnt[i] of CNT_W bits:
  - sync==stable: cnt<=0 in the same cycle, regardless of tick.
  - sync!=stable and tick, cnt<DB_TICKS-1: cnt<=cnt+1.
  - sync!=stable and tick, cnt==DB_TICKS-1: stable<=sync, cnt<=0, and the press or release strobe is registered in that same cycle.
  - sync!=stable and no tick: hold.
  - cnt never exceeds DB_TICKS-1; there is no wrap-around.
- Output timing: btn_o=stable. btn_o and the strobe become visible together in the cycle after the accepting tick.
- Debounce latency from a btn_raw_i edge to btn_o: 2 + (DB_TICKS-1)*TICK_DIV + k + 1 cycles, where k is in 1..TICK_DIV depending on tick phase.
- Strobes are exactly one cycle wide. press and release never assert together for the same bit.
- Sticky events:
  - evt_o[i] <= btn_press_o[i] | (evt_o[i] & ~evt_clr_i[i]).
  - A set coinciding with a clear wins: the bit stays 1.
  - Releases do not affect evt_o.
- irq_o: registered |evt_o, lagging evt_o by 1 cycle.
- Reset mid-count: everything clears, including cnt, tick phase and evt.
  - A button held through reset deassertion is treated as a fresh 0->1 change.
  - It produces btn_o=1 and one press strobe after the full debounce latency.
- Buttons are fully independent. Simultaneous acceptance on several bits strobes each of them in the same cycle.

Decomposition:
- Package arty_btn_pkg: default constants ARTY_BTN_TICK_DIV and ARTY_BTN_DB_TICKS, plus a function deriving TICK_DIV from core clock frequency and a millisecond value.
- Sub-module arty_btn_db_cell: one bit containing sync, stable, cnt and strobe generation, with tick as an input. Instantiate N_BTN times in a generate loop.
- The tick generator and sticky/IRQ logic live in the top module.
- Elaboration assertions: TICK_DIV>=1 and DB_TICKS>=1.

Test Plan (bench uses TICK_DIV=4, DB_TICKS=3, N_BTN=4):
- Clean press: btn_raw_i[0] goes 0->1 at cycle 0 and is held. btn_o[0]=1 at a cycle in 12..15. btn_press_o[0] is 1 for exactly that cycle. evt_o[0]=1 the same cycle, irq_o=1 one cycle later. Bits 1..3 stay 0.
- Bounce rejection: btn_raw_i[1] toggles every 3 cycles for 30 cycles, then is held at 1. No strobe during bouncing. Exactly one press strobe 12..15 cycles after the final edge.
- Glitch filter: btn_raw_i[2] is high for 6 cycles only. btn_o[2] stays 0, no strobes, evt_o stays 0.
- Release plus clear race: after a debounced press on bit 3, drop btn_raw_i[3]. One release strobe follows, and evt_o[3] stays 1. Pulse evt_clr_i[3] for one cycle: evt_o[3]=0 next cycle, irq_o=0 the cycle after. Then force evt_clr_i[0] in the same cycle as btn_press_o[0]: evt_o[0]=1.
- Multi-button: all four raw bits rise in the same cycle. All press strobes assert in a single common cycle, and irq_o asserts once.
- Reset mid-operation: assert pwrup_rst_n=0 with cnt[0]=2 and btn_raw_i[0] held at 1. All outputs read 0 during reset. After deassertion, btn_o[0]=1 and one press strobe appear 12..15 cycles later.

Source files
------------

// File: rtl/arty_btn_pkg.sv
// Shared constants and helpers for the Arty push-button conditioning stage.
// Latency: n/a (package). Backpressure: n/a.
// Contents: default tick divider / debounce depth and a divider helper.
package arty_btn_pkg;

  // 1 ms sample tick at the 25 MHz board clock.
  localparam int ARTY_BTN_TICK_DIV = 25000;
  // Ten consecutive disagreeing ticks before a new level is accepted.
  localparam int ARTY_BTN_DB_TICKS = 10;

  // Clock cycles per tick for a given core frequency and tick period in ms.
  // Clamped to 1 so a tiny clock still yields a legal divider.
  function automatic int arty_btn_tick_div(input int clk_hz, input int ms);
    int div;
    div = (clk_hz / 1000) * ms;
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/arty_btn_db_cell.sv
// Single-button synchroniser + debouncer with registered press/release strobes.
// Latency: 2 sync cycles, then DB_TICKS ticks; level and strobe appear together.
// Backpressure: none; strobes are one-cycle pulses with no handshake.
// Ports: cpu_clk, pwrup_rst_n (async, active-low), btn_raw (async input),
//        tick (sample enable), btn (debounced level), btn_press / btn_release.
module arty_btn_db_cell #(
  parameter int DB_TICKS = 10
) (
  input  logic cpu_clk,
  input  logic pwrup_rst_n,
  input  logic btn_raw,
  input  logic tick,
  output logic btn,
  output logic btn_press,
  output logic btn_release
);

  localparam int CNT_W = $clog2(DB_TICKS + 1);

  logic [1:0]       sync_q;
  logic             sync;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             mismatch;
  logic             accept;

  assign sync     = sync_q[1];
  assign mismatch = sync ^ stable;
  // The last disagreeing tick flips the level instead of bumping cnt, so
  // cnt tops out at DB_TICKS-1 and never wraps.
  assign accept   = mismatch & tick & (cnt == CNT_W'(DB_TICKS - 1));
  assign btn      = stable;

  always_ff @(posedge cpu_clk or negedge pwrup_rst_n) begin
    if (!pwrup_rst_n) begin
      sync_q      <= '0;
      stable      <= 1'b0;
      cnt         <= '0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], btn_raw};
      // Registered alongside stable so level and strobe show up in one cycle.
      btn_press   <= accept & sync;
      btn_release <= accept & ~sync;
      if (!mismatch) begin
        // Any agreement restarts the count, tick or not.
        cnt <= '0;
      end else if (tick) begin
        if (accept) begin
          stable <= sync;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/arty_btn_debounce.sv
// Push-button conditioning: sync + debounce per button, sticky press events, IRQ.
// Latency: 2 + (DB_TICKS-1)*TICK_DIV + k + 1 cycles raw->btn_o; irq_o one after evt_o.
// Backpressure: none; events are sticky until cleared via evt_clr_i.
// Ports: cpu_clk, pwrup_rst_n (async, active-low), btn_raw_i, btn_o, btn_press_o,
//        btn_release_o, evt_clr_i (level-sampled per-bit clear), evt_o, irq_o.
module arty_btn_debounce
  import arty_btn_pkg::*;
#(
  parameter int N_BTN    = 4,
  parameter int TICK_DIV = ARTY_BTN_TICK_DIV,
  parameter int DB_TICKS = ARTY_BTN_DB_TICKS
) (
  input  logic             cpu_clk,
  input  logic             pwrup_rst_n,
  input  logic [N_BTN-1:0] btn_raw_i,
  output logic [N_BTN-1:0] btn_o,
  output logic [N_BTN-1:0] btn_press_o,
  output logic [N_BTN-1:0] btn_release_o,
  input  logic [N_BTN-1:0] evt_clr_i,
  output logic [N_BTN-1:0] evt_o,
  output logic             irq_o
);

  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("arty_btn_debounce: TICK_DIV must be >= 1");
  end
  if (DB_TICKS < 1) begin : g_bad_db_ticks
    $error("arty_btn_debounce: DB_TICKS must be >= 1");
  end

  // Counter must hold TICK_DIV-1; keep at least one bit for TICK_DIV=1.
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TW-1:0] tick_cnt;
  logic          tick;

  // Shared sample tick: one cycle high whenever the down-counter hits zero.
  assign tick = (tick_cnt == '0);

  always_ff @(posedge cpu_clk or negedge pwrup_rst_n) begin
    if (!pwrup_rst_n) begin
      tick_cnt <= TW'(TICK_DIV - 1);
    end else if (tick) begin
      tick_cnt <= TW'(TICK_DIV - 1);
    end else begin
      tick_cnt <= tick_cnt - TW'(1);
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_cell
    arty_btn_db_cell #(
      .DB_TICKS (DB_TICKS)
    ) u_cell (
      .cpu_clk     (cpu_clk),
      .pwrup_rst_n (pwrup_rst_n),
      .btn_raw     (btn_raw_i[i]),
      .tick        (tick),
      .btn         (btn_o[i]),
      .btn_press   (btn_press_o[i]),
      .btn_release (btn_release_o[i])
    );
  end

  // A press arriving in the same cycle as its clear keeps the event set.
  always_ff @(posedge cpu_clk or negedge pwrup_rst_n) begin
    if (!pwrup_rst_n) begin
      evt_o <= '0;
      irq_o <= 1'b0;
    end else begin
      evt_o <= btn_press_o | (evt_o & ~evt_clr_i);
      irq_o <= |evt_o;
    end
  end

endmodule

// File: tb/tb_arty_btn_debounce.sv
module tb_arty_btn_debounce;

  logic       cpu_clk = 1'b0;
  logic       pwrup_rst_n = 1'b0;
  logic [3:0] btn_raw = '0;
  logic [3:0] evt_clr = '0;
  logic [3:0] btn, press, rel, evt;
  logic       irq;

  int checks = 0;
  int failures = 0;
  int cyc;

  int   lat, np, nr;
  logic sac, en1, in2;
  int   total, first, irq_rises;
  logic [3:0] pv;
  logic prev_irq;

  always #5 cpu_clk = ~cpu_clk;

  // Cycles since reset release; after the release edge the tick fires on
  // the period where cyc%4==3, so raw edges applied at cyc%4==3 give a
  // deterministic latency of 13 cycles (12 right after reset).
  always @(posedge cpu_clk or negedge pwrup_rst_n)
    if (!pwrup_rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  arty_btn_debounce #(.N_BTN(4), .TICK_DIV(4), .DB_TICKS(3)) dut (
    .cpu_clk       (cpu_clk),
    .pwrup_rst_n   (pwrup_rst_n),
    .btn_raw_i     (btn_raw),
    .btn_o         (btn),
    .btn_press_o   (press),
    .btn_release_o (rel),
    .evt_clr_i     (evt_clr),
    .evt_o         (evt),
    .irq_o         (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic align();
    do step(); while (cyc % 4 != 3);
  endtask

  // Watch bit b for ncyc cycles; optionally drop its raw input after drop_at cycles.
  task automatic observe(input int b, input int ncyc, input int drop_at,
                         output int chg, output int n_p, output int n_r,
                         output logic strobe_at_chg, output logic evt_n1, output logic irq_n2);
    logic prev;
    prev = btn[b];
    chg = -1; n_p = 0; n_r = 0;
    strobe_at_chg = 1'b0; evt_n1 = 1'b0; irq_n2 = 1'b0;
    for (int i = 1; i <= ncyc; i++) begin
      if (i - 1 == drop_at) btn_raw[b] = 1'b0;
      step();
      n_p += int'(press[b]);
      n_r += int'(rel[b]);
      if (chg < 0 && btn[b] != prev) begin
        chg = i;
        strobe_at_chg = prev ? rel[b] : press[b];
      end else if (chg > 0 && i == chg + 1) begin
        evt_n1 = evt[b];
      end else if (chg > 0 && i == chg + 2) begin
        irq_n2 = irq;
      end
    end
  endtask

  function automatic logic in_win(input int l);
    return (l >= 12 && l <= 15);
  endfunction

  initial begin
    // Reset state
    repeat (3) @(posedge cpu_clk);
    #1;
    chk("reset_outs", {15'd0, btn, press, rel, evt, irq}, 32'd0);
    step();
    pwrup_rst_n = 1'b1;

    // Clean press on bit 0
    align();
    btn_raw[0] = 1'b1;
    observe(0, 22, -1, lat, np, nr, sac, en1, in2);
    chk($sformatf("press0_lat=%0d_in_12..15", lat), in_win(lat), 1);
    chk("press0_strobe_with_level", sac, 1);
    chk("press0_one_strobe", np, 1);
    chk("press0_no_release", nr, 0);
    chk("press0_evt", en1, 1);
    chk("press0_irq_lag", in2, 1);
    chk("idle_bits_1to3", {26'd0, btn[3:1], evt[3:1]}, 0);

    // Bounce rejection on bit 1
    align();
    total = 0;
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) btn_raw[1] = ~btn_raw[1];
      step();
      total += int'(press[1]) + int'(rel[1]);
    end
    chk("bounce_no_strobe", total, 0);
    chk("bounce_level_low", btn[1], 0);
    align();
    btn_raw[1] = 1'b1;
    observe(1, 22, -1, lat, np, nr, sac, en1, in2);
    chk($sformatf("bounce_lat=%0d_in_12..15", lat), in_win(lat), 1);
    chk("bounce_one_press", np, 1);

    // Glitch filter on bit 2: high for 6 cycles only
    align();
    btn_raw[2] = 1'b1;
    observe(2, 25, 6, lat, np, nr, sac, en1, in2);
    chk("glitch_no_level", lat, -1);
    chk("glitch_no_strobes", np + nr, 0);
    chk("glitch_no_evt", evt[2], 0);

    // Clear all events
    evt_clr = 4'hF;
    step();
    evt_clr = 4'h0;
    chk("clr_all_evt", evt, 0);
    step();
    chk("clr_all_irq", irq, 0);

    // Press then release on bit 3
    align();
    btn_raw[3] = 1'b1;
    observe(3, 22, -1, lat, np, nr, sac, en1, in2);
    chk($sformatf("press3_lat=%0d_in_12..15", lat), in_win(lat), 1);
    chk("press3_one_strobe", np, 1);
    align();
    btn_raw[3] = 1'b0;
    observe(3, 22, -1, lat, np, nr, sac, en1, in2);
    chk($sformatf("rel3_lat=%0d_in_12..15", lat), in_win(lat), 1);
    chk("rel3_strobe_with_level", sac, 1);
    chk("rel3_one_release", nr, 1);
    chk("rel3_no_press", np, 0);
    chk("rel3_evt_kept", evt[3], 1);
    evt_clr[3] = 1'b1;
    step();
    evt_clr = 4'h0;
    chk("clr3_evt", evt[3], 0);
    chk("clr3_irq_lags", irq, 1);
    step();
    chk("clr3_irq", irq, 0);

    // Set/clear race on bit 0
    align();
    btn_raw[0] = 1'b0;
    observe(0, 22, -1, lat, np, nr, sac, en1, in2);
    chk("rel0_one_release", nr, 1);
    evt_clr[0] = 1'b1;
    align();
    btn_raw[0] = 1'b1;
    observe(0, 22, -1, lat, np, nr, sac, en1, in2);
    evt_clr = 4'h0;
    chk("race_press", np, 1);
    chk("race_set_wins", en1, 1);

    // Multi-button simultaneous press
    btn_raw = 4'h0;
    repeat (20) step();
    chk("all_released", btn, 0);
    evt_clr = 4'hF;
    step();
    evt_clr = 4'h0;
    step();
    align();
    btn_raw = 4'hF;
    first = -1; pv = '0; total = 0; irq_rises = 0; prev_irq = irq;
    for (int i = 1; i <= 22; i++) begin
      step();
      total += $countones(press);
      if (first < 0 && press != 4'h0) begin
        first = i;
        pv = press;
      end
      if (irq && !prev_irq) irq_rises++;
      prev_irq = irq;
    end
    chk("multi_common_strobe", pv, 4'hF);
    chk($sformatf("multi_lat=%0d_in_12..15", first), in_win(first), 1);
    chk("multi_total_strobes", total, 4);
    chk("multi_irq_once", irq_rises, 1);

    // Reset mid-count with bit 0 held high
    btn_raw = 4'h0;
    repeat (20) step();
    align();
    btn_raw[0] = 1'b1;
    repeat (10) step();
    pwrup_rst_n = 1'b0;
    #1;
    chk("midrst_outs", {15'd0, btn, press, rel, evt, irq}, 32'd0);
    step();
    chk("midrst_outs_held", {15'd0, btn, press, rel, evt, irq}, 32'd0);
    pwrup_rst_n = 1'b1;
    observe(0, 22, -1, lat, np, nr, sac, en1, in2);
    chk($sformatf("postrst_lat=%0d_in_12..15", lat), in_win(lat), 1);
    chk("postrst_one_press", np, 1);
    chk("postrst_level", btn[0], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
